// File: rtl/sig_dump_ctrl_if.sv
// Bus bundle for the signature dump controller: data-bus snoop, memory
// read port, signature word stream and run status.
interface sig_dump_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                    snoop_req_i;
    logic [DATA_WIDTH/8-1:0] snoop_we_i;
    logic [ADDR_WIDTH-1:0]   snoop_addr_i;
    logic [DATA_WIDTH-1:0]   snoop_wdata_i;
    logic                    rd_req_o;
    logic [ADDR_WIDTH-1:0]   rd_addr_o;
    logic                    rd_rvalid_i;
    logic [DATA_WIDTH-1:0]   rd_rdata_i;
    logic                    rd_err_i;
    logic                    sig_valid_o;
    logic [DATA_WIDTH-1:0]   sig_data_o;
    logic                    sig_ready_i;
    logic                    done_o;
    logic [1:0]              status_o;
    logic [ADDR_WIDTH-1:0]   word_cnt_o;

    // controller side
    modport master (
        input  snoop_req_i, snoop_we_i, snoop_addr_i, snoop_wdata_i,
        input  rd_rvalid_i, rd_rdata_i, rd_err_i, sig_ready_i,
        output rd_req_o, rd_addr_o, sig_valid_o, sig_data_o,
        output done_o, status_o, word_cnt_o
    );

    // harness side (core bus, SRAM read port, signature consumer)
    modport slave (
        output snoop_req_i, snoop_we_i, snoop_addr_i, snoop_wdata_i,
        output rd_rvalid_i, rd_rdata_i, rd_err_i, sig_ready_i,
        input  rd_req_o, rd_addr_o, sig_valid_o, sig_data_o,
        input  done_o, status_o, word_cnt_o
    );
endinterface

// File: rtl/sig_dump_ctrl.sv
// Compliance-run controller: snoops core writes for the halt flag and the
// signature bounds, aborts on a cycle timeout, then reads the signature
// region back one word at a time and streams it out over valid/ready.
module sig_dump_ctrl #(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    ADDR_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] HALT_ADDR      = 32'h001F_FFF4,
    parameter logic [ADDR_WIDTH-1:0] SIG_END_ADDR   = 32'h001F_FFF8,
    parameter logic [ADDR_WIDTH-1:0] SIG_START_ADDR = 32'h001F_FFFC,
    parameter int unsigned           TIMEOUT        = 1000000,
    parameter int                    CNT_WIDTH      = 32
) (
    input logic             clk_i,
    input logic             rstn_i,
    sig_dump_ctrl_if.master bus
);
    localparam logic [ADDR_WIDTH-1:0] STEP    = ADDR_WIDTH'(DATA_WIDTH / 8);
    localparam logic [CNT_WIDTH-1:0]  TO_LAST = (TIMEOUT == 0) ? '0 : CNT_WIDTH'(TIMEOUT - 1);

    typedef enum logic [2:0] {S_RUN, S_FETCH, S_WAIT, S_OUT, S_DONE} state_t;

    state_t                state;
    logic [CNT_WIDTH-1:0]  cnt;
    logic [ADDR_WIDTH-1:0] sig_start;
    logic [ADDR_WIDTH-1:0] sig_end;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [ADDR_WIDTH-1:0] ptr_inc;
    logic [ADDR_WIDTH-1:0] wdata_aligned;
    logic [ADDR_WIDTH-1:0] start_nxt;
    logic [ADDR_WIDTH-1:0] end_nxt;
    logic                  wr;
    logic                  halt_ev;
    logic                  to_ev;

    // only full-word writes count; partial-byte stores are ignored
    assign wr            = bus.snoop_req_i && (&bus.snoop_we_i);
    assign wdata_aligned = ADDR_WIDTH'(bus.snoop_wdata_i) & ~ADDR_WIDTH'(3);
    assign halt_ev       = wr && (bus.snoop_addr_i == HALT_ADDR) && bus.snoop_wdata_i[0];
    assign to_ev         = (TIMEOUT != 0) && (cnt == TO_LAST);
    assign ptr_inc       = ptr + STEP;

    // bound registers as they will be after this edge, so a halt seen in the
    // same cycle as a bound write dumps with the new value
    always_comb begin
        start_nxt = sig_start;
        end_nxt   = sig_end;
        if (wr && bus.snoop_addr_i == SIG_START_ADDR) start_nxt = wdata_aligned;
        if (wr && bus.snoop_addr_i == SIG_END_ADDR)   end_nxt   = wdata_aligned;
    end

    // run / fetch / wait / output / done sequencer with registered outputs
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state           <= S_RUN;
            cnt             <= '0;
            sig_start       <= '0;
            sig_end         <= '0;
            ptr             <= '0;
            bus.rd_req_o    <= 1'b0;
            bus.rd_addr_o   <= '0;
            bus.sig_valid_o <= 1'b0;
            bus.sig_data_o  <= '0;
            bus.done_o      <= 1'b0;
            bus.status_o    <= 2'b00;
            bus.word_cnt_o  <= '0;
        end else begin
            case (state)
                S_RUN: begin
                    cnt       <= cnt + CNT_WIDTH'(1);
                    sig_start <= start_nxt;
                    sig_end   <= end_nxt;
                    if (halt_ev || to_ev) begin
                        // halt takes precedence over a coincident timeout
                        bus.status_o <= halt_ev ? 2'b01 : 2'b10;
                        ptr          <= start_nxt;
                        if (start_nxt >= end_nxt) begin
                            bus.done_o <= 1'b1;
                            state      <= S_DONE;
                        end else begin
                            bus.rd_req_o  <= 1'b1;
                            bus.rd_addr_o <= start_nxt;
                            state         <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    bus.rd_req_o <= 1'b0;
                    state        <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.rd_err_i) begin
                        bus.status_o <= 2'b11;
                        bus.done_o   <= 1'b1;
                        state        <= S_DONE;
                    end else if (bus.rd_rvalid_i) begin
                        bus.sig_data_o  <= bus.rd_rdata_i;
                        bus.sig_valid_o <= 1'b1;
                        state           <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (bus.sig_ready_i) begin
                        bus.sig_valid_o <= 1'b0;
                        bus.word_cnt_o  <= bus.word_cnt_o + ADDR_WIDTH'(1);
                        ptr             <= ptr_inc;
                        if (ptr_inc >= sig_end) begin
                            bus.done_o <= 1'b1;
                            state      <= S_DONE;
                        end else begin
                            bus.rd_req_o  <= 1'b1;
                            bus.rd_addr_o <= ptr_inc;
                            state         <= S_FETCH;
                        end
                    end
                end
                S_DONE: ;
                default: state <= S_RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_sig_dump_ctrl.sv
// Bench for sig_dump_ctrl: table of halt-driven dumps plus hand sequences
// for timeout, ready back-pressure, read error and mid-dump reset.
module tb_sig_dump_ctrl;
    localparam logic [31:0] HALT  = 32'h001F_FFF4;
    localparam logic [31:0] SEND  = 32'h001F_FFF8;
    localparam logic [31:0] SSTRT = 32'h001F_FFFC;

    typedef struct {
        logic [31:0] s;
        logic [31:0] e;
        logic [31:0] hd;
        int          words;
        logic [1:0]  st;
    } vec_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    sig_dump_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) b ();
    sig_dump_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) z ();

    sig_dump_ctrl #(.TIMEOUT(50)) dut  (.clk_i(clk), .rstn_i(rstn), .bus(b));
    sig_dump_ctrl #(.TIMEOUT(0))  dut0 (.clk_i(clk), .rstn_i(rstn), .bus(z));

    int tests = 0, fails = 0;
    int cyc = 0, rel_cyc = 0, first_req_cyc = -1;
    int req_cnt = 0, hs_cnt = 0, z_req = 0;
    int pend = 0, pend_idx = 0, lat = 1, err_at = -1, ready_mode = 0;
    logic [31:0] pend_addr = '0;
    logic        hold = 1'b0;
    logic [31:0] hold_data = '0;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    vec_t vt[5];

    function automatic logic [31:0] mem_f(logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // SRAM responder, consumer ready driver and output scoreboard
    always @(negedge clk) begin
        cyc++;
        b.rd_rvalid_i = 1'b0;
        b.rd_err_i    = 1'b0;
        b.rd_rdata_i  = '0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                if (pend_idx == err_at) b.rd_err_i = 1'b1;
                else begin
                    b.rd_rvalid_i = 1'b1;
                    b.rd_rdata_i  = mem_f(pend_addr);
                end
            end
        end
        b.sig_ready_i = (ready_mode == 0) ? 1'b1 : (cyc % 3 == 0);
        if (hold) begin
            check("hold_valid", b.sig_valid_o, 1);
            check("hold_data", b.sig_data_o, hold_data);
        end
        if (b.rd_req_o) begin
            if (first_req_cyc < 0) first_req_cyc = cyc;
            if (exp_addr_q.size() == 0) check("extra_read", 1, 0);
            else check("rd_addr", b.rd_addr_o, exp_addr_q.pop_front());
            pend      = lat;
            pend_addr = b.rd_addr_o;
            pend_idx  = req_cnt;
            req_cnt++;
        end
        if (b.sig_valid_o && b.sig_ready_i) begin
            hs_cnt++;
            if (exp_data_q.size() == 0) check("extra_word", 1, 0);
            else check("sig_data", b.sig_data_o, exp_data_q.pop_front());
        end
        hold      = b.sig_valid_o && !b.sig_ready_i;
        hold_data = b.sig_data_o;
        if (z.rd_req_o) z_req++;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        rstn = 1'b0;
        pend = 0; req_cnt = 0; hs_cnt = 0; z_req = 0; first_req_cyc = -1;
        hold = 1'b0; lat = 1; err_at = -1; ready_mode = 0;
        exp_addr_q.delete();
        exp_data_q.delete();
        b.snoop_req_i = 1'b0; b.snoop_we_i = '0; b.snoop_addr_i = '0; b.snoop_wdata_i = '0;
        tick();
        tick();
        #1 rstn = 1'b1;
        rel_cyc = cyc;
    endtask

    task automatic bus_wr(logic [31:0] a, logic [31:0] d);
        tick();
        b.snoop_req_i = 1'b1; b.snoop_we_i = 4'hF; b.snoop_addr_i = a; b.snoop_wdata_i = d;
        tick();
        b.snoop_req_i = 1'b0; b.snoop_we_i = '0;
    endtask

    task automatic expect_dump(logic [31:0] s, logic [31:0] e);
        logic [31:0] a, ea;
        a  = s & ~32'h3;
        ea = e & ~32'h3;
        while (a < ea) begin
            exp_addr_q.push_back(a);
            exp_data_q.push_back(mem_f(a));
            a += 32'd4;
        end
    endtask

    task automatic wait_done(int maxc);
        int n = 0;
        while (!b.done_o && n < maxc) begin
            tick();
            n++;
        end
        check("done_reached", b.done_o, 1);
    endtask

    initial begin
        int n;
        vt[0] = '{32'h2000, 32'h2010, 32'h1,        4, 2'b01};
        vt[1] = '{32'h3003, 32'h3008, 32'h1,        2, 2'b01};
        vt[2] = '{32'h0500, 32'h0500, 32'h1,        0, 2'b01};
        vt[3] = '{32'h4000, 32'h4004, 32'hFFFFFFFF, 1, 2'b01};
        vt[4] = '{32'h6010, 32'h6000, 32'h1,        0, 2'b01};
        z.snoop_req_i = 1'b0; z.snoop_we_i = '0; z.snoop_addr_i = '0; z.snoop_wdata_i = '0;
        z.rd_rvalid_i = 1'b0; z.rd_rdata_i = '0; z.rd_err_i = 1'b0; z.sig_ready_i = 1'b1;
        b.rd_rvalid_i = 1'b0; b.rd_rdata_i = '0; b.rd_err_i = 1'b0; b.sig_ready_i = 1'b1;

        do_reset();
        check("reset_outputs", {b.rd_req_o, b.sig_valid_o, b.done_o, b.status_o,
                                b.word_cnt_o, b.rd_addr_o, b.sig_data_o}, 0);

        // halt-driven dumps
        foreach (vt[i]) begin
            do_reset();
            expect_dump(vt[i].s, vt[i].e);
            bus_wr(SSTRT, vt[i].s);
            bus_wr(SEND, vt[i].e);
            bus_wr(HALT, vt[i].hd);
            if (vt[i].words == 0) check("done_next_cycle", b.done_o, 1);
            wait_done(300);
            check("status", b.status_o, vt[i].st);
            check("word_cnt", b.word_cnt_o, vt[i].words);
            check("handshakes", hs_cnt, vt[i].words);
            check("reads", req_cnt, vt[i].words);
            check("data_left", exp_data_q.size(), 0);
        end

        // halt with bit0 clear is ignored; timeout then dumps one word
        do_reset();
        expect_dump(32'h100, 32'h104);
        bus_wr(SSTRT, 32'h100);
        bus_wr(SEND, 32'h104);
        bus_wr(HALT, 32'h2);
        repeat (5) tick();
        check("halt_bit0_ignored", {b.done_o, b.status_o, 6'(req_cnt)}, 0);
        wait_done(200);
        check("timeout_cycle", first_req_cyc - rel_cyc, 50);
        check("timeout_status", b.status_o, 2'b10);
        check("timeout_words", b.word_cnt_o, 1);
        check("timeout_hs", hs_cnt, 1);

        // TIMEOUT=0 never dumps; the timed-out instance with empty bounds ends with no words
        do_reset();
        repeat (200) tick();
        check("no_timeout_done", {z.done_o, z.status_o}, 0);
        check("no_timeout_reads", z_req, 0);
        check("empty_timeout", {b.done_o, b.status_o, b.word_cnt_o}, {1'b1, 2'b10, 32'd0});
        check("empty_timeout_reads", req_cnt, 0);

        // back-pressure then read error on the second read
        do_reset();
        ready_mode = 1;
        err_at = 1;
        exp_addr_q.push_back(32'h7000);
        exp_addr_q.push_back(32'h7004);
        exp_data_q.push_back(mem_f(32'h7000));
        bus_wr(SSTRT, 32'h7000);
        bus_wr(SEND, 32'h7010);
        bus_wr(HALT, 32'h1);
        wait_done(300);
        check("err_status", b.status_o, 2'b11);
        check("err_words", b.word_cnt_o, 1);
        check("err_hs", hs_cnt, 1);
        check("err_reads", req_cnt, 2);
        // DONE ignores further bus writes
        bus_wr(SSTRT, 32'h0);
        bus_wr(HALT, 32'h1);
        repeat (3) tick();
        check("done_frozen", {b.done_o, b.status_o, b.word_cnt_o}, {1'b1, 2'b11, 32'd1});
        check("done_no_reads", req_cnt, 2);

        // async reset while waiting on a slow read, then a full dump
        do_reset();
        lat = 5;
        expect_dump(32'h8000, 32'h8008);
        bus_wr(SSTRT, 32'h8000);
        bus_wr(SEND, 32'h8008);
        bus_wr(HALT, 32'h1);
        n = 0;
        while (req_cnt == 0 && n < 20) begin
            tick();
            n++;
        end
        check("wait_read_seen", req_cnt, 1);
        tick();
        rstn = 1'b0;
        #1;
        check("async_reset_outputs", {b.rd_req_o, b.sig_valid_o, b.done_o, b.status_o}, 0);
        do_reset();
        expect_dump(32'h8000, 32'h8010);
        bus_wr(SSTRT, 32'h8000);
        bus_wr(SEND, 32'h8010);
        bus_wr(HALT, 32'h1);
        wait_done(300);
        check("redump_status", b.status_o, 2'b01);
        check("redump_words", b.word_cnt_o, 4);
        check("redump_hs", hs_cnt, 4);
        check("redump_left", exp_addr_q.size() + exp_data_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end
endmodule

// File: doc/sig_dump_ctrl.md
Name: sig_dump_ctrl

Overview:
- Synthesizable compliance-run controller for the jedro_1 test harness. Replaces hard-coded testbench polling.
- Snoops core data-bus writes to catch the halt flag and the signature start/end addresses. Aborts on a cycle timeout.
- After halt or timeout, reads the signature region back through a dedicated memory read port and streams it out as a valid/ready word stream.
- Sits beside the data SRAM, driven by the same bus wires as the core's data port.

Parameters:
- DATA_WIDTH, 32, bus and signature word width (multiple of 8).
- ADDR_WIDTH, 32, byte-address width.
- HALT_ADDR, 32'h001F_FFF4, byte address of halt flag register.
- SIG_END_ADDR, 32'h001F_FFF8, byte address of signature end register.
- SIG_START_ADDR, 32'h001F_FFFC, byte address of signature start register.
- TIMEOUT, 1000000, cycles from reset release to forced dump; 0 disables the timeout.
- CNT_WIDTH, 32, width of the timeout counter (must hold TIMEOUT).

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  asynchronous active-low reset
- snoop_req_i  in  1  data-bus request from core
- snoop_we_i  in  DATA_WIDTH/8  data-bus byte write enables
- snoop_addr_i  in  ADDR_WIDTH  data-bus byte address
- snoop_wdata_i  in  DATA_WIDTH  data-bus write data
- rd_req_o  out  1  memory read request, one-cycle pulse
- rd_addr_o  out  ADDR_WIDTH  memory read byte address (word aligned)
- rd_rvalid_i  in  1  read data valid
- rd_rdata_i  in  DATA_WIDTH  read data
- rd_err_i  in  1  read error
- sig_valid_o  out  1  signature word valid
- sig_data_o  out  DATA_WIDTH  signature word
- sig_ready_i  in  1  consumer ready
- done_o  out  1  dump finished; sticky until reset
- status_o  out  2  00 running/dumping, 01 halted, 10 timeout, 11 read error
- word_cnt_o  out  ADDR_WIDTH  number of signature words emitted so far

Behaviour:
- Reset values: all outputs 0, state RUN, counter 0, captured start/end 0. Reset is async; rstn_i low mid-dump returns to RUN immediately and drops rd_req_o/sig_valid_o the same instant.
- Snoop capture (RUN only):
  - A write is snoop_req_i=1 with all snoop_we_i bits set, on a rising edge.
  - Partial-byte writes are ignored.
  - Write to SIG_START_ADDR or SIG_END_ADDR: latch wdata with bits [1:0] cleared.
  - Write to HALT_ADDR: halt event only if wdata[0]=1.
- Timeout: counter increments every cycle in RUN. When counter reaches TIMEOUT-1 and TIMEOUT≠0, raise a timeout event.
- Halt and timeout in the same cycle: halt wins, status 01.
- Halt in the same cycle as a start/end write: the register write is committed first, and the dump uses the new value.
- FSM:
  - RUN: on event, set status (01/10) and ptr=start. If start>=end (unsigned), go to DONE (0 words). Else go to FETCH.
  - FETCH: drive rd_req_o=1 and rd_addr_o=ptr for exactly one cycle, then go to WAIT.
  - WAIT: hold until rd_rvalid_i or rd_err_i (any latency ≥1).
    - On rd_err_i (takes priority if both asserted): status=11, go to DONE, no word emitted.
    - On rd_rvalid_i: register rdata into sig_data_o, assert sig_valid_o, go to OUT.
  - OUT: hold sig_valid_o/sig_data_o stable until sig_ready_i=1. On the handshake cycle: word_cnt++, ptr+=DATA_WIDTH/8. If the new ptr>=end, go to DONE, else go to FETCH.
  - DONE: done_o=1. Status and word_cnt_o are frozen. Bus writes are ignored. Only reset exits.
- One outstanding read at a time. Minimum per-word latency is 3 cycles with 1-cycle SRAM and sig_ready_i held high.
- Pointer arithmetic is ADDR_WIDTH unsigned. If ptr wraps past the top, it compares < end, but since end ≤ top this cannot occur when start<end.
- Snoop writes outside RUN are ignored. The counter stops outside RUN.

Test Plan:
- Write start=0x2000, end=0x2010, then halt=1; memory returns words A,B,C,D; ready held 1 -> four handshakes with data A..D, reads issued at 0x2000/04/08/0C, status=01, done_o=1, word_cnt_o=4.
- Write start=0x3003, end=0x3008, halt=1 -> aligned start 0x3000, end 0x3008, exactly 2 words emitted.
- TIMEOUT=50, no halt write, start=0x100, end=0x104 -> timeout event at cycle 49 after reset release, status=10, 1 word emitted. Same test with TIMEOUT=0 -> no dump within 200 cycles.
- start=0x500, end=0x500, halt=1 -> done_o next cycle, word_cnt_o=0, rd_req_o never pulses. Halt write with wdata=2 -> ignored, stays RUN.
- sig_ready_i toggled 0,0,1 pattern -> sig_data_o stable while ready=0, no extra rd_req_o. rd_err_i on second read -> status=11, word_cnt_o=1, done.
- Assert rstn_i low during WAIT -> rd_req_o, sig_valid_o, done_o=0 immediately. After release, a new halt sequence completes a full dump.
